// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared palette, text cell field layout and cursor constants
package text_pkg;

    // text_data word = {attr, ascii}
    localparam int TEXT_ASCII_LSB = 0;
    localparam int TEXT_ATTR_LSB  = 8;

    // fields inside the attribute byte
    localparam int ATTR_FG_LSB    = 0;
    localparam int ATTR_FG_W      = 4;
    localparam int ATTR_BG_LSB    = 4;
    localparam int ATTR_BG_W      = 3;
    localparam int ATTR_BLINK_BIT = 7;

    localparam int CURSOR_UL_H = 2;

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    function automatic logic [11:0] palette_lookup(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/text_pixel_pipe_if.sv
// rtl/text_pixel_pipe_if.sv - pixel in, text RAM / font ROM ports and colour out
interface text_pixel_pipe_if #(
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16,
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int XY_W    = 10
);
    localparam int TA_W = $clog2(COLS * ROWS);
    localparam int FA_W = 8 + $clog2(GLYPH_H);

    logic                pix_valid;
    logic [XY_W-1:0]     x;
    logic [XY_W-1:0]     y;
    logic [TA_W-1:0]     text_addr;
    logic                text_rd_en;
    logic [15:0]         text_data;
    logic [FA_W-1:0]     font_addr;
    logic [GLYPH_W-1:0]  font_data;
    logic [11:0]         rgb;
    logic                rgb_valid;

    modport master (
        output pix_valid, x, y, text_data, font_data,
        input  text_addr, text_rd_en, font_addr, rgb, rgb_valid
    );

    modport slave (
        input  pix_valid, x, y, text_data, font_data,
        output text_addr, text_rd_en, font_addr, rgb, rgb_valid
    );

endinterface

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - frame counter that toggles the blink phase every BLINK_FRAMES frames
module blink_timer #(
    parameter int BLINK_FRAMES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic blink_phase
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt         <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/text_pixel_pipe.sv
// rtl/text_pixel_pipe.sv - 3-stage text-mode renderer: cell lookup, glyph fetch, colour
module text_pixel_pipe
    import text_pkg::*;
#(
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int XY_W         = 10,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     cursor_en,
    input  logic                     cursor_block,
    input  logic [$clog2(COLS)-1:0]  cursor_col,
    input  logic [$clog2(ROWS)-1:0]  cursor_row,
    text_pixel_pipe_if.slave         bus
);
    localparam int GX_W = $clog2(GLYPH_W);
    localparam int GY_W = $clog2(GLYPH_H);
    localparam int TA_W = $clog2(COLS * ROWS);

    logic                  blink_phase;
    logic [XY_W-GX_W-1:0]  cell_col;
    logic [XY_W-GY_W-1:0]  cell_row;
    logic [GX_W-1:0]       gcol;
    logic [GY_W-1:0]       grow;
    logic                  in_range;
    logic                  cursor_hit;

    logic                  s1_valid, s1_in_range, s1_hit, s1_phase;
    logic [GX_W-1:0]       s1_gcol;
    logic [GY_W-1:0]       s1_grow;

    logic                  s2_valid, s2_in_range, s2_hit, s2_phase;
    logic [GX_W-1:0]       s2_gcol;
    logic [7:0]            s2_attr;

    logic [GX_W-1:0]       bit_idx;
    logic                  pix_bit;
    logic [3:0]            fg_idx;
    logic [3:0]            bg_idx;
    logic [11:0]           pix_rgb;

    blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .blink_phase (blink_phase)
    );

    // Stage 0: cell coordinates come straight from bit slices of x/y
    always_comb begin
        cell_col   = bus.x[XY_W-1:GX_W];
        cell_row   = bus.y[XY_W-1:GY_W];
        gcol       = bus.x[GX_W-1:0];
        grow       = bus.y[GY_W-1:0];
        in_range   = (32'(bus.x) < 32'(COLS * GLYPH_W)) && (32'(bus.y) < 32'(ROWS * GLYPH_H));
        cursor_hit = cursor_en && blink_phase
                  && (32'(cell_col) == 32'(cursor_col))
                  && (32'(cell_row) == 32'(cursor_row))
                  && (cursor_block || (32'(grow) >= 32'(GLYPH_H - CURSOR_UL_H)));
    end

    assign bus.text_addr  = TA_W'(cell_row) * TA_W'(COLS) + TA_W'(cell_col);
    assign bus.text_rd_en = bus.pix_valid && in_range && !rst;

    // Stage 1: text_data has arrived; ask the font ROM for the glyph row
    assign bus.font_addr = {bus.text_data[TEXT_ASCII_LSB +: 8], s1_grow};

    // Blink phase is captured with the pixel so a same-cycle frame_start cannot affect it
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= bus.pix_valid;
            s2_valid <= s1_valid;
        end
        s1_in_range <= in_range;
        s1_hit      <= cursor_hit;
        s1_phase    <= blink_phase;
        s1_gcol     <= gcol;
        s1_grow     <= grow;

        s2_in_range <= s1_in_range;
        s2_hit      <= s1_hit;
        s2_phase    <= s1_phase;
        s2_gcol     <= s1_gcol;
        s2_attr     <= bus.text_data[TEXT_ATTR_LSB +: 8];
    end

    // Stage 2: MSB of the glyph row is the leftmost pixel
    always_comb begin
        bit_idx = GX_W'(GLYPH_W - 1) - s2_gcol;
        pix_bit = bus.font_data[bit_idx] ^ s2_hit;
        bg_idx  = {1'b0, s2_attr[ATTR_BG_LSB +: ATTR_BG_W]};
        fg_idx  = s2_attr[ATTR_FG_LSB +: ATTR_FG_W];
        if (s2_attr[ATTR_BLINK_BIT] && !s2_phase) begin
            fg_idx = bg_idx;
        end
        pix_rgb = 12'h000;
        if (s2_valid && s2_in_range) begin
            pix_rgb = pix_bit ? palette_lookup(fg_idx) : palette_lookup(bg_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rgb       <= 12'h000;
            bus.rgb_valid <= 1'b0;
        end else begin
            bus.rgb       <= pix_rgb;
            bus.rgb_valid <= s2_valid;
        end
    end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// tb/tb_text_pixel_pipe.sv - directed self-checking bench for text_pixel_pipe
module tb_text_pixel_pipe;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       cursor_en;
    logic       cursor_block;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] tram [0:2399];

    text_pixel_pipe_if #(.GLYPH_W(8), .GLYPH_H(16), .COLS(80), .ROWS(30), .XY_W(10)) bus ();

    text_pixel_pipe #(
        .GLYPH_W(8), .GLYPH_H(16), .COLS(80), .ROWS(30), .XY_W(10), .BLINK_FRAMES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .cursor_en    (cursor_en),
        .cursor_block (cursor_block),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] font_row(input logic [7:0] ascii);
        if (ascii == 8'h41) return 8'h18;
        if (ascii == 8'hDB) return 8'hFF;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (bus.text_rd_en) bus.text_data <= tram[bus.text_addr];
        bus.font_data <= font_row(bus.font_addr[11:4]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the pipeline empty.
    task automatic pixel(input string tag, input int px, input int py, input logic fs,
                         input logic exp_rd, input logic [11:0] exp_rgb);
        bus.pix_valid = 1'b1;
        bus.x         = 10'(px);
        bus.y         = 10'(py);
        frame_start   = fs;
        #1 check({tag, "_rd"}, 32'(bus.text_rd_en), 32'(exp_rd));
        @(negedge clk);
        bus.pix_valid = 1'b0;
        frame_start   = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, 32'(bus.rgb_valid), 32'd0);
        check({tag, "_idle_rgb"}, 32'(bus.rgb), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.rgb_valid), 32'd1);
        check({tag, "_rgb"}, 32'(bus.rgb), 32'(exp_rgb));
        @(negedge clk);
        check({tag, "_late"}, 32'(bus.rgb_valid), 32'd0);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        int bad_addr;
        int bad_valid;
        int n_valid;
        int seen;

        for (int i = 0; i < 2400; i++) tram[i] = 16'h0720;
        tram[0] = 16'h1F41;
        tram[5] = 16'h9F41;

        rst = 1'b1; frame_start = 1'b0; cursor_en = 1'b0; cursor_block = 1'b0;
        cursor_col = 7'd0; cursor_row = 5'd0;
        bus.pix_valid = 1'b0; bus.x = '0; bus.y = '0;
        repeat (3) @(negedge clk);

        check("rst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
        check("rst_rgb", 32'(bus.rgb), 32'd0);
        check("rst_phase", 32'(dut.blink_phase), 32'd1);
        bus.pix_valid = 1'b1; bus.x = 10'd3; bus.y = 10'd5;
        #1 check("rst_rd_en", 32'(bus.text_rd_en), 32'd0);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        pixel("hit_x3", 3, 5, 1'b0, 1'b1, 12'hFFF);
        pixel("hit_x0", 0, 5, 1'b0, 1'b1, 12'h00A);
        pixel("hit_x4", 4, 5, 1'b0, 1'b1, 12'hFFF);
        pixel("hit_x7", 7, 5, 1'b0, 1'b1, 12'h00A);
        pixel("blank_cell", 9, 5, 1'b0, 1'b1, 12'h000);

        pixel("oor_x640", 640, 0, 1'b0, 1'b0, 12'h000);
        pixel("oor_y480", 0, 480, 1'b0, 1'b0, 12'h000);
        pixel("last_cell", 639, 479, 1'b0, 1'b1, 12'h000);

        cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 5'd1; cursor_block = 1'b0;
        pixel("ul_grow14", 18, 30, 1'b0, 1'b1, 12'hAAA);
        pixel("ul_grow15", 18, 31, 1'b0, 1'b1, 12'hAAA);
        pixel("ul_grow13", 18, 29, 1'b0, 1'b1, 12'h000);
        pixel("ul_other_cell", 26, 31, 1'b0, 1'b1, 12'h000);
        cursor_block = 1'b1;
        pixel("blk_grow0", 18, 16, 1'b0, 1'b1, 12'hAAA);
        cursor_en = 1'b0;
        pixel("cursor_off", 18, 16, 1'b0, 1'b1, 12'h000);

        pixel("blink_on0", 43, 5, 1'b0, 1'b1, 12'hFFF);
        pulse_frame();
        check("phase_f1", 32'(dut.blink_phase), 32'd1);
        pixel("blink_same_cycle", 43, 5, 1'b1, 1'b1, 12'hFFF);
        check("phase_f2", 32'(dut.blink_phase), 32'd0);
        pixel("blink_off_fg", 43, 5, 1'b0, 1'b1, 12'h00A);
        pixel("blink_off_bg", 40, 5, 1'b0, 1'b1, 12'h00A);
        cursor_en = 1'b1;
        pixel("cursor_phase0", 18, 16, 1'b0, 1'b1, 12'h000);
        cursor_en = 1'b0;
        pulse_frame();
        check("phase_f3", 32'(dut.blink_phase), 32'd0);
        pulse_frame();
        check("phase_f4", 32'(dut.blink_phase), 32'd1);
        pixel("blink_on1", 43, 5, 1'b0, 1'b1, 12'hFFF);

        bad_addr = 0; bad_valid = 0; n_valid = 0;
        for (int k = 0; k < 646; k++) begin
            if (k < 640) begin
                bus.pix_valid = 1'b1; bus.x = 10'(k); bus.y = 10'd0;
            end else begin
                bus.pix_valid = 1'b0;
            end
            #1;
            if (k < 640 && bus.text_addr !== 12'(k / 8)) bad_addr++;
            if (bus.rgb_valid !== ((k >= 3) && (k < 643))) bad_valid++;
            if (bus.rgb_valid === 1'b1) n_valid++;
            @(negedge clk);
        end
        check("stream_addr_err", 32'(bad_addr), 32'd0);
        check("stream_valid_err", 32'(bad_valid), 32'd0);
        check("stream_valid_count", 32'(n_valid), 32'd640);

        pulse_frame();
        pulse_frame();
        check("pre_rst_phase", 32'(dut.blink_phase), 32'd0);
        bus.pix_valid = 1'b1; bus.x = 10'd3; bus.y = 10'd5;
        @(negedge clk);
        bus.x = 10'd4;
        @(negedge clk);
        rst = 1'b1; bus.x = 10'd16;
        @(negedge clk);
        #1;
        check("mid_rst_rgb_valid", 32'(bus.rgb_valid), 32'd0);
        check("mid_rst_rgb", 32'(bus.rgb), 32'd0);
        check("mid_rst_rd_en", 32'(bus.text_rd_en), 32'd0);
        check("mid_rst_phase", 32'(dut.blink_phase), 32'd1);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rgb_valid !== 1'b0) seen++;
        end
        check("flushed_no_valid", 32'(seen), 32'd0);
        pixel("post_rst", 3, 5, 1'b0, 1'b1, 12'hFFF);
        pulse_frame();
        check("post_rst_cnt_cleared", 32'(dut.blink_phase), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_pixel_pipe.md
TEXT_PIXEL_PIPE -- requirements
Module: text_pixel_pipe

Interface
REQ-001 Parameter GLYPH_W, default 8, glyph width in pixels; power of two; font ROM word width equals GLYPH_W.
REQ-002 Parameter GLYPH_H, default 16, glyph height in pixels; power of two.
REQ-003 Parameter COLS, default 80, text columns per screen.
REQ-004 Parameter ROWS, default 30, text rows per screen.
REQ-005 Parameter XY_W, default 10, width of the pixel coordinates.
REQ-006 Parameter BLINK_FRAMES, default 32, frames per blink half-period; minimum 1.
REQ-007 Ports, one per line:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  x/y valid this cycle
- x, y  in  XY_W each  screen pixel coordinate
- frame_start  in  1  one-cycle pulse per frame
- cursor_en  in  1  cursor display enable
- cursor_block  in  1  1 = block cursor, 0 = underline cursor
- cursor_col, cursor_row  in  clog2(COLS), clog2(ROWS)  cursor cell
- text_addr  out  clog2(COLS*ROWS)  text RAM address
- text_rd_en  out  1  text RAM read strobe
- text_data  in  16  {attr[7:0], ascii[7:0]}; valid 1 cycle after text_rd_en
- font_addr  out  8+clog2(GLYPH_H)  {ascii, glyph row}
- font_data  in  GLYPH_W  glyph row; valid 1 cycle after font_addr
- rgb  out  12  pixel colour
- rgb_valid  out  1  rgb valid

Function
REQ-008 The block SHALL be a 3-stage pipeline with no backpressure: rgb_valid at cycle t+3 SHALL equal pix_valid at cycle t.
REQ-009 Stage 0 SHALL compute cell column = x/GLYPH_W, cell row = y/GLYPH_H, gcol = x mod GLYPH_W and grow = y mod GLYPH_H by bit slicing, drive text_addr = cell_row*COLS + cell_col, and drive text_rd_en = pix_valid AND in_range.
REQ-010 in_range SHALL be defined as x < COLS*GLYPH_W AND y < ROWS*GLYPH_H; an out-of-range valid pixel SHALL produce rgb = 12'h000 with rgb_valid = 1.
REQ-011 Stage 1 SHALL drive font_addr = {text_data[7:0], grow} and register attr, gcol, in_range and the cursor hit.
REQ-012 Stage 2 SHALL select pixel bit = font_data[GLYPH_W-1-gcol], so the MSB is the leftmost pixel.
REQ-013 attr[3:0] SHALL be the foreground index, attr[6:4] the background index (0-7), and attr[7] the blink flag; indices map to colours through the shared palette.
REQ-014 A blink character (attr[7]=1) SHALL render its foreground as the background colour while blink_phase = 0.
REQ-015 Cursor hit SHALL mean cursor_en=1 AND blink_phase=1 AND the cell equals (cursor_col, cursor_row) AND (cursor_block=1 OR grow >= GLYPH_H-2); on a hit the selected bit SHALL be inverted before colour lookup.
REQ-016 The blink counter SHALL increment on each frame_start; when it equals BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase on the same edge.
REQ-017 If frame_start and pix_valid are high in the same cycle, blink_phase SHALL affect only pixels entering stage 0 in a later cycle.
REQ-018 When pix_valid = 0, rgb SHALL be 12'h000 at the corresponding output cycle and text_rd_en SHALL be 0.

Reset
REQ-019 While rst = 1: rgb = 12'h000, rgb_valid = 0, text_rd_en = 0, all pipeline valid bits = 0, blink counter = 0, blink_phase = 1.
REQ-020 Reset asserted mid-stream SHALL discard in-flight pixels; the first rgb_valid after rst falls SHALL appear 3 cycles after the first pix_valid sampled with rst = 0.

Structure
REQ-021 The shared package text_pkg SHALL hold the 16-entry 12-bit palette constant, the text cell field positions, and the cursor underline height (2).
REQ-022 Blink timing SHALL be a sub-module named blink_timer (inputs clk, rst, frame_start; output blink_phase).
REQ-023 The font ROM and text RAM SHALL be external to this block.

Verification
REQ-024 Pixel hit: cell (0,0) = 16'h1F41, font row 5 = 8'h18, x=3, y=5, pix_valid for 1 cycle -> rgb = palette[15] with rgb_valid exactly 3 cycles later; x=0 -> palette[1].
REQ-025 Out of range: x=640, y=0, defaults -> text_rd_en=0 and rgb=12'h000, rgb_valid=1 at t+3.
REQ-026 Blink: BLINK_FRAMES=2 with 4 frame_start pulses -> blink_phase sequence 1,1,0,0,1; a blink char's foreground disappears while phase=0.
REQ-027 Underline cursor at (2,1), grow 14 and 15 -> bits inverted; grow 13 -> not inverted; cursor_block=1 -> all rows inverted.
REQ-028 Streaming 640 consecutive valid pixels -> 640 consecutive rgb_valid cycles with no gap and text_addr increments every 8 pixels.
REQ-029 Reset at stream cycle 2 -> no rgb_valid for the flushed pixels, blink_phase=1, and outputs match REQ-019.
